logic_issue_queue: RTL and testbench
====================================

// Module: logic_issue_queue
// PURPOSE
//   Issue stage placed directly upstream of the 32-bit combinational logic unit.
//   Buffers {a, b, select, tag} commands in a FIFO and drives the head entry onto the unit.
//   Registers the unit's result with its tag and offers it downstream under valid/ready.
//   Decouples bursty producers from the result consumer; adds no arithmetic of its own.
// PARAMETERS
//   DEPTH    4   FIFO entries; power of 2, >= 2
//   TAG_W    4   width of the caller-supplied command tag
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   flush      in   1      sync clear of FIFO and result register
//   in_valid   in   1      command offered
//   in_ready   out  1      FIFO can accept (= !full)
//   in_a       in   32     operand a
//   in_b       in   32     operand b
//   in_sel     in   3      logic-unit select code, passed through unchanged
//   in_tag     in   TAG_W  command tag
//   lu_a       out  32     head operand a to logic unit
//   lu_b       out  32     head operand b to logic unit
//   lu_select  out  3      head select to logic unit
//   lu_out     in   32     combinational result returned by logic unit
//   res_valid  out  1      result register holds a result
//   res_ready  in   1      downstream accepts result
//   res_data   out  32     captured lu_out
//   res_tag    out  TAG_W  tag of the captured command
//   count      out  log2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   - Reset (async, rst_n=0): rd/wr pointers 0, count 0, res_valid 0, res_data 0, res_tag 0,
//     FIFO storage 0, so lu_a/lu_b/lu_select read 0; in_ready 1 once rst_n released.
//   - Push: in_valid & in_ready at an edge writes the entry at wr_ptr, and wr_ptr increments mod DEPTH.
//   - lu_a/lu_b/lu_select are taken combinationally from the entry at rd_ptr. When empty they show
//     stale storage, which is don't-care.
//   - Pop/capture: pop = !empty & (!res_valid | res_ready). On pop: res_data<=lu_out,
//     res_tag<=head tag, res_valid<=1, and rd_ptr increments.
//   - Drain without pop: res_valid & res_ready & empty -> res_valid<=0; data/tag hold.
//   - Latency: command accepted at edge N is at the head at N+1 (if the FIFO was empty) and
//     res_valid=1 after edge N+1. Throughput is one command per cycle with res_ready held 1.
//   - Full: in_ready=0 while count==DEPTH. A same-cycle pop does not raise in_ready, so there is
//     no pass-through when full.
//   - Simultaneous push and pop (not full): count unchanged, both pointers advance.
//   - Wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count.
//   - flush=1 beats push and pop: pointers 0, count 0, res_valid 0, and any in_valid in that
//     cycle is dropped. in_ready is 1 the next cycle.
//   - res_data/res_tag are stable while res_valid & !res_ready (AXI-style hold rule).
//   - Reset mid-operation discards all queued commands and any pending result immediately.
// CONFIGURATION
//   LOGIC_ISSUE_FLAGS_EN defined:
//     - adds output res_zero (1) = (captured result == 0) and output res_parity (1) = ^captured result;
//     - both are registered with res_data, reset to 0 and cleared by flush.
//   LOGIC_ISSUE_FLAGS_EN undefined: neither port exists; all other behaviour is identical.
// TESTING
//   1 Single op: push a=F0F0F0F0 b=FF00FF00 sel=0 tag=3, model returns a&b
//     -> res_valid after 2 edges, res_data=F000F000, res_tag=3.
//   2 Fill: res_ready=0, push 5 cmds with DEPTH=4 -> 4 accepted, in_ready=0, count=4,
//     5th held until a pop occurs.
//   3 Streaming: res_ready=1, push tags 0..7 back-to-back -> results in order 0..7,
//     one per cycle, count never exceeds 1.
//   4 Backpressure: res_ready=0 for 3 cycles with a result pending -> res_data/res_tag constant,
//     head not popped.
//   5 Flush with FIFO at count=3 and res_valid=1, plus in_valid high -> next cycle count=0,
//     res_valid=0, and the pushed command is lost.
//   6 Async reset pulsed mid-stream (not clock-aligned) -> all outputs 0 immediately.
//     With FLAGS_EN, a=b=0 sel=0 gives res_zero=1 and res_parity=0.

Source files
------------

// File: rtl/logic_issue_queue.sv
// Command FIFO and result register wrapped around a 32-bit combinational logic unit.
// Optional feature macro: LOGIC_ISSUE_FLAGS_EN adds registered res_zero/res_parity outputs.
module logic_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [2:0]               in_sel,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              lu_a,
  output logic [31:0]              lu_b,
  output logic [2:0]               lu_select,
  input  logic [31:0]              lu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [TAG_W-1:0]         res_tag,
`ifdef LOGIC_ISSUE_FLAGS_EN
  output logic                     res_zero,
  output logic                     res_parity,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      mem_a_q   [DEPTH];
  logic [31:0]      mem_a_d   [DEPTH];
  logic [31:0]      mem_b_q   [DEPTH];
  logic [31:0]      mem_b_d   [DEPTH];
  logic [2:0]       mem_sel_q [DEPTH];
  logic [2:0]       mem_sel_d [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_d [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_zero_q, res_zero_d;
  logic             res_parity_q, res_parity_d;

  logic empty, full, push, pop;

  // Full/empty come from the occupancy count so pointer equality never has to be disambiguated.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = in_valid & ~full & ~flush;
  assign pop   = ~empty & (~res_valid_q | res_ready) & ~flush;

  assign in_ready  = ~full;
  assign lu_a      = mem_a_q[rd_ptr_q];
  assign lu_b      = mem_b_q[rd_ptr_q];
  assign lu_select = mem_sel_q[rd_ptr_q];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign count     = count_q;

`ifdef LOGIC_ISSUE_FLAGS_EN
  assign res_zero   = res_zero_q;
  assign res_parity = res_parity_q;
`endif

  always_comb begin
    mem_a_d   = mem_a_q;
    mem_b_d   = mem_b_q;
    mem_sel_d = mem_sel_q;
    mem_tag_d = mem_tag_q;
    if (push) begin
      mem_a_d[wr_ptr_q]   = in_a;
      mem_b_d[wr_ptr_q]   = in_b;
      mem_sel_d[wr_ptr_q] = in_sel;
      mem_tag_d[wr_ptr_q] = in_tag;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flush wipes the whole result register, flags included, so nothing stale is offered afterwards.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_zero_d   = res_zero_q;
    res_parity_d = res_parity_q;
    if (flush) begin
      res_valid_d  = 1'b0;
      res_data_d   = '0;
      res_tag_d    = '0;
      res_zero_d   = 1'b0;
      res_parity_d = 1'b0;
    end else if (pop) begin
      res_valid_d  = 1'b1;
      res_data_d   = lu_out;
      res_tag_d    = mem_tag_q[rd_ptr_q];
      res_zero_d   = (lu_out == 32'd0);
      res_parity_d = ^lu_out;
    end else if (res_valid_q & res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_sel_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      res_zero_q   <= 1'b0;
      res_parity_q <= 1'b0;
    end else begin
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_sel_q    <= mem_sel_d;
      mem_tag_q    <= mem_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_zero_q   <= res_zero_d;
      res_parity_q <= res_parity_d;
    end
  end

endmodule

// File: tb/tb_logic_issue_queue.sv
// Directed self-checking bench for logic_issue_queue; a small behavioural logic unit closes the loop.
// Compile with LOGIC_ISSUE_FLAGS_EN to also exercise res_zero/res_parity.
module tb_logic_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_sel;
  logic [3:0]  in_tag;
  logic [31:0] lu_a;
  logic [31:0] lu_b;
  logic [2:0]  lu_select;
  logic [31:0] lu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [2:0]  count;
`ifdef LOGIC_ISSUE_FLAGS_EN
  logic        res_zero;
  logic        res_parity;
`endif

  int total;
  int bad;
  logic [31:0] exp_tab [8];
  logic [31:0] held_data;

  logic_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_tag    (in_tag),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_select (lu_select),
    .lu_out    (lu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
`ifdef LOGIC_ISSUE_FLAGS_EN
    .res_zero  (res_zero),
    .res_parity(res_parity),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream combinational logic unit.
  always_comb begin
    case (lu_select)
      3'd0:    lu_out = lu_a & lu_b;
      3'd1:    lu_out = lu_a | lu_b;
      3'd2:    lu_out = lu_a ^ lu_b;
      3'd3:    lu_out = ~(lu_a & lu_b);
      3'd4:    lu_out = ~(lu_a | lu_b);
      3'd5:    lu_out = ~(lu_a ^ lu_b);
      3'd6:    lu_out = ~lu_a;
      default: lu_out = lu_a;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] sel, input logic [3:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_tag   = tag;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_tab[0] = 32'hF000F000;
    exp_tab[1] = 32'hFFF0FFF0;
    exp_tab[2] = 32'h0FF00FF0;
    exp_tab[3] = 32'h0FFF0FFF;
    exp_tab[4] = 32'h000F000F;
    exp_tab[5] = 32'hF00FF00F;
    exp_tab[6] = 32'h0F0F0F0F;
    exp_tab[7] = 32'hF0F0F0F0;

    rst_n     = 1'b0;
    flush     = 1'b0;
    res_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    #12 rst_n = 1'b1;
    #2;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_lu_a", lu_a, 32'd0);
    @(negedge clk);

    $display("[TB] single op");
    applyStimulus(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 4'd3);
    stepClock();
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    checkOutput("single_count_n", 32'(count), 32'd1);
    checkOutput("single_valid_n", 32'(res_valid), 32'd0);
    checkOutput("single_head_a", lu_a, 32'hF0F0F0F0);
    stepClock();
    checkOutput("single_valid", 32'(res_valid), 32'd1);
    checkOutput("single_data", res_data, 32'hF000F000);
    checkOutput("single_tag", 32'(res_tag), 32'd3);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("bp_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_data", res_data, 32'hF000F000);
      checkOutput("bp_tag", 32'(res_tag), 32'd3);
    end

    $display("[TB] fill");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 32'(i), 32'hFFFF0000, 3'd2, 4'(i));
      stepClock();
      checkOutput("fill_count", 32'(count), (i < 4) ? 32'(i) : 32'd4);
    end
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    checkOutput("fill_head_a", lu_a, 32'd1);
    checkOutput("fill_hold_tag", 32'(res_tag), 32'd3);
    res_ready = 1'b1;
    stepClock();
    res_ready = 1'b0;
    checkOutput("full_pop_count", 32'(count), 32'd3);
    checkOutput("full_pop_tag", 32'(res_tag), 32'd1);
    checkOutput("full_pop_data", res_data, 32'hFFFF0001);
    checkOutput("full_pop_ready", 32'(in_ready), 32'd1);
    stepClock();
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    checkOutput("fifth_count", 32'(count), 32'd4);
    res_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      stepClock();
      checkOutput("drain_tag", 32'(res_tag), 32'(i));
      checkOutput("drain_data", res_data, 32'hFFFF0000 | 32'(i));
      checkOutput("drain_count", 32'(count), 32'(5 - i));
    end
    stepClock();
    checkOutput("drain_empty_valid", 32'(res_valid), 32'd0);

    $display("[TB] streaming");
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) applyStimulus(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'(k), 4'(k));
      else applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
      stepClock();
      checkOutput("stream_count", 32'(count), (k < 8) ? 32'd1 : 32'd0);
      if (k >= 1) begin
        checkOutput("stream_valid", 32'(res_valid), 32'd1);
        checkOutput("stream_tag", 32'(res_tag), 32'(k - 1));
        checkOutput("stream_data", res_data, exp_tab[k-1]);
      end
    end
    stepClock();
    checkOutput("stream_end_valid", 32'(res_valid), 32'd0);

    $display("[TB] flush");
    res_ready = 1'b0;
    for (int i = 8; i < 12; i++) begin
      applyStimulus(1'b1, 32'(i), 32'd0, 3'd1, 4'(i));
      stepClock();
    end
    checkOutput("preflush_count", 32'(count), 32'd3);
    checkOutput("preflush_valid", 32'(res_valid), 32'd1);
    checkOutput("preflush_tag", 32'(res_tag), 32'd8);
    flush = 1'b1;
    applyStimulus(1'b1, 32'hDEADBEEF, 32'd0, 3'd1, 4'd12);
    stepClock();
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(res_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    stepClock();
    checkOutput("flush_lost_count", 32'(count), 32'd0);
    checkOutput("flush_lost_valid", 32'(res_valid), 32'd0);

    $display("[TB] async reset");
    res_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000FFFF, 32'h00FF00FF, 3'd1, 4'd5);
    stepClock();
    applyStimulus(1'b1, 32'h12345678, 32'd0, 3'd7, 4'd6);
    stepClock();
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    held_data = res_data;
    checkOutput("prereset_data", held_data, 32'h00FFFFFF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_valid", 32'(res_valid), 32'd0);
    checkOutput("async_data", res_data, 32'd0);
    checkOutput("async_tag", 32'(res_tag), 32'd0);
    #4 rst_n = 1'b1;
    stepClock();
    checkOutput("postreset_count", 32'(count), 32'd0);
    checkOutput("postreset_valid", 32'(res_valid), 32'd0);

`ifdef LOGIC_ISSUE_FLAGS_EN
    applyStimulus(1'b1, 32'd0, 32'd0, 3'd0, 4'd9);
    stepClock();
    applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    stepClock();
    checkOutput("flags_valid", 32'(res_valid), 32'd1);
    checkOutput("flags_zero", 32'(res_zero), 32'd1);
    checkOutput("flags_parity", 32'(res_parity), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
